// File: rtl/string_job_sequencer.sv
// string_job_sequencer
//   Drives the string compute engine from the operand FIFOs, one job at a time.
//   For each job it pops N (A,B) word pairs, runs each pair through the engine
//   with a go/done handshake, and pushes each result into the result FIFO.
//   A completion pulse follows the last push. If the engine stays silent past
//   TIMEOUT cycles, the job is aborted and a sticky error flag is raised.
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   cmd_start/words/length  job command (accepted only when idle)
//   busy, job_done,
//   job_error, words_done   job status
//   a_* / b_*               show-ahead operand FIFOs (empty, head data, pop)
//   eng_*                   engine handshake, registered operands, index, length
//   res_full/push/wdata     result FIFO write side
module string_job_sequencer #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [CNT_W-1:0]  cmd_words,
  input  logic [2:0]        cmd_length,
  output logic              busy,
  output logic              job_done,
  output logic              job_error,
  output logic [CNT_W-1:0]  words_done,
  input  logic              a_empty,
  input  logic [DATA_W-1:0] a_rdata,
  output logic              a_pop,
  input  logic              b_empty,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              b_pop,
  output logic              eng_go,
  output logic [DATA_W-1:0] eng_a,
  output logic [DATA_W-1:0] eng_b,
  output logic [2:0]        eng_index,
  output logic [2:0]        eng_length,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result,
  input  logic              res_full,
  output logic              res_push,
  output logic [DATA_W-1:0] res_wdata
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, STORE, FINISH} state_t;

  localparam int               TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(16);

  state_t           state, nxt;
  logic [CNT_W-1:0] words_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             last_word;

  // The counter holds 0..TIMEOUT-1 while waiting, so reaching the last value
  // means TIMEOUT full WAIT cycles have elapsed.
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign last_word = ((words_done + CNT_W'(1)) == words_q);

  always_comb begin
    nxt      = state;
    busy     = (state != IDLE);
    job_done = 1'b0;
    a_pop    = 1'b0;
    b_pop    = 1'b0;
    eng_go   = 1'b0;
    res_push = 1'b0;
    case (state)
      IDLE:   if (cmd_start) nxt = (cmd_words == '0) ? FINISH : FETCH;
      FETCH:  if (!a_empty && !b_empty) begin
                // Pops are paired so the two operand streams never skew.
                a_pop = 1'b1;
                b_pop = 1'b1;
                nxt   = ISSUE;
              end
      ISSUE:  begin
                eng_go = 1'b1;
                nxt    = WAIT;
              end
      WAIT:   if (eng_done)     nxt = STORE;
              else if (tmo_hit) nxt = FINISH;
      STORE:  if (!res_full) begin
                res_push = 1'b1;
                nxt      = last_word ? FINISH : FETCH;
              end
      FINISH: begin
                job_done = 1'b1;
                nxt      = IDLE;
              end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      words_q    <= '0;
      tmo_cnt    <= '0;
      words_done <= '0;
      job_error  <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
      eng_index  <= '0;
      eng_length <= '0;
      res_wdata  <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (cmd_start) begin
          // Out-of-range word counts are clamped so words_done stays <= 16.
          words_q    <= (cmd_words > MAX_WORDS) ? MAX_WORDS : cmd_words;
          eng_length <= cmd_length;
          words_done <= '0;
          eng_index  <= '0;
          job_error  <= 1'b0;
        end
        FETCH: if (a_pop) begin
          eng_a <= a_rdata;
          eng_b <= b_rdata;
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          if (eng_done)     res_wdata <= eng_result;
          else if (tmo_hit) job_error <= 1'b1;
          else              tmo_cnt   <= tmo_cnt + TMO_W'(1);
        end
        STORE: if (res_push) begin
          words_done <= words_done + CNT_W'(1);
          eng_index  <= eng_index + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_string_job_sequencer.sv
module tb_string_job_sequencer;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_start;
  logic [CNT_W-1:0]  cmd_words;
  logic [2:0]        cmd_length;
  logic              busy, job_done, job_error;
  logic [CNT_W-1:0]  words_done;
  logic              a_empty, b_empty, a_pop, b_pop;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              eng_go, eng_done;
  logic [DATA_W-1:0] eng_a, eng_b, eng_result;
  logic [2:0]        eng_index, eng_length;
  logic              res_full, res_push;
  logic [DATA_W-1:0] res_wdata;

  string_job_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_words(cmd_words), .cmd_length(cmd_length),
    .busy(busy), .job_done(job_done), .job_error(job_error), .words_done(words_done),
    .a_empty(a_empty), .a_rdata(a_rdata), .a_pop(a_pop),
    .b_empty(b_empty), .b_rdata(b_rdata), .b_pop(b_pop),
    .eng_go(eng_go), .eng_a(eng_a), .eng_b(eng_b),
    .eng_index(eng_index), .eng_length(eng_length),
    .eng_done(eng_done), .eng_result(eng_result),
    .res_full(res_full), .res_push(res_push), .res_wdata(res_wdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DATA_W-1:0] data; logic [2:0] idx; } push_t;
  typedef struct { logic [CNT_W-1:0] words; logic err; } done_t;

  push_t             exp_push[$];
  done_t             exp_done[$];
  logic [DATA_W-1:0] qa[$], qb[$];
  int                n_cmp = 0, n_err = 0;
  logic [2:0]        exp_len = '0;
  bit                eng_en = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic push_t mk_push(input logic [DATA_W-1:0] d, input logic [2:0] i);
    push_t p; p.data = d; p.idx = i; return p;
  endfunction

  function automatic done_t mk_done(input logic [CNT_W-1:0] w, input logic e);
    done_t d; d.words = w; d.err = e; return d;
  endfunction

  // Show-ahead FIFO models: pops seen in a cycle take effect just after the edge.
  initial begin
    bit pa, pb;
    a_empty = 1'b1; b_empty = 1'b1; a_rdata = '0; b_rdata = '0;
    forever begin
      @(negedge clk); pa = a_pop; pb = b_pop;
      @(posedge clk); #2;
      if (pa && qa.size() != 0) void'(qa.pop_front());
      if (pb && qb.size() != 0) void'(qb.pop_front());
      a_empty = (qa.size() == 0); a_rdata = a_empty ? '0 : qa[0];
      b_empty = (qb.size() == 0); b_rdata = b_empty ? '0 : qb[0];
    end
  end

  // Engine model: result A+B, done pulse two cycles after go.
  initial begin
    logic [DATA_W-1:0] ra, rb;
    eng_done = 1'b0; eng_result = '0;
    forever begin
      @(negedge clk);
      if (eng_go && eng_en && !reset) begin
        ra = eng_a; rb = eng_b;
        chk("eng_length", 64'(eng_length), 64'(exp_len));
        @(posedge clk); @(posedge clk); #1;
        eng_done = 1'b1; eng_result = ra + rb;
        @(posedge clk); #1;
        eng_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (res_push) begin
        if (exp_push.size() == 0) chk("unexpected_push", 64'(res_wdata), 64'hDEAD_0000);
        else begin
          push_t e;
          e = exp_push.pop_front();
          chk("res_wdata", 64'(res_wdata), 64'(e.data));
          chk("push_index", 64'(eng_index), 64'(e.idx));
        end
      end
      if (job_done) begin
        if (exp_done.size() == 0) chk("unexpected_job_done", 64'(words_done), 64'hDEAD_0001);
        else begin
          done_t d;
          d = exp_done.pop_front();
          chk("words_done", 64'(words_done), 64'(d.words));
          chk("job_error", 64'(job_error), 64'(d.err));
        end
      end
      if (a_pop || b_pop)
        chk("pop_pair", 64'({a_pop, b_pop, a_empty, b_empty}), 64'(4'b1100));
    end
  end

  task automatic wait_sig(input int sel, input int maxc, input string nm);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < maxc) begin
      @(negedge clk); n++;
      case (sel)
        0: hit = eng_go;
        1: hit = job_done;
        2: hit = res_push;
        default: hit = eng_done;
      endcase
    end
    chk(nm, 64'(hit), 64'd1);
  endtask

  task automatic start_job(input int w, input int len);
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_words = CNT_W'(w); cmd_length = 3'(len); exp_len = 3'(len);
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 64'({busy, job_done, job_error, a_pop, b_pop, eng_go, res_push}), 64'd0);
    chk({nm, "_cnt"}, 64'({words_done, eng_index, eng_length}), 64'd0);
    chk({nm, "_data"}, 64'(eng_a | eng_b | res_wdata), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; cmd_start = 1'b0; cmd_words = '0; cmd_length = '0; res_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); chk_zero("reset_state");
    @(posedge clk); #1 reset = 1'b0;

    // 1. Normal three-word job
    qa = '{32'd1, 32'd2, 32'd3}; qb = '{32'd10, 32'd20, 32'd30};
    exp_push.push_back(mk_push(32'd11, 3'd0));
    exp_push.push_back(mk_push(32'd22, 3'd1));
    exp_push.push_back(mk_push(32'd33, 3'd2));
    exp_done.push_back(mk_done(5'd3, 1'b0));
    start_job(3, 4);
    @(negedge clk); chk("t1_busy", 64'(busy), 64'd1); chk("t1_pop_T+1", 64'(a_pop), 64'd1);
    @(negedge clk); chk("t1_go_T+2", 64'(eng_go), 64'd1);
    wait_sig(1, 100, "t1_job_done_seen");

    // 2. Empty job
    exp_done.push_back(mk_done(5'd0, 1'b0));
    start_job(0, 1);
    @(negedge clk);
    chk("t2_busy_done", 64'({busy, job_done}), 64'(2'b11));
    chk("t2_no_activity", 64'({a_pop, eng_go, res_push}), 64'd0);
    @(negedge clk); chk("t2_idle_after", 64'(busy), 64'd0);

    // 3. Operand stall: B empty for 5 cycles
    qa.push_back(32'd4);
    exp_push.push_back(mk_push(32'd44, 3'd0));
    exp_done.push_back(mk_done(5'd1, 1'b0));
    start_job(1, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t3_no_pop_stalled", 64'({a_pop, b_pop}), 64'd0);
      @(posedge clk); #1;
    end
    qb.push_back(32'd40);
    @(negedge clk); chk("t3_pop_both", 64'({a_pop, b_pop}), 64'(2'b11));
    wait_sig(1, 50, "t3_job_done_seen");

    // 4. Result backpressure
    res_full = 1'b1;
    qa.push_back(32'd5); qb.push_back(32'd6);
    exp_push.push_back(mk_push(32'd11, 3'd0));
    exp_done.push_back(mk_done(5'd1, 1'b0));
    start_job(1, 3);
    wait_sig(3, 50, "t4_eng_done_seen");
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_no_push_full", 64'(res_push), 64'd0);
      chk("t4_wdata_stable", 64'(res_wdata), 64'd11);
      @(posedge clk);
    end
    #1 res_full = 1'b0;
    wait_sig(1, 50, "t4_job_done_seen");

    // 5. Timeout, sticky error, command filtering
    eng_en = 1'b0;
    qa.push_back(32'd9); qb.push_back(32'd9);
    exp_done.push_back(mk_done(5'd0, 1'b1));
    start_job(1, 6);
    wait_sig(0, 50, "t5_go_seen");
    n = 0;
    do begin @(negedge clk); n++; end while (!job_done && n < 40);
    chk("t5_go_to_done_cycles", 64'(n), 64'd9);
    repeat (3) @(negedge clk);
    chk("t5_error_sticky", 64'({busy, job_error}), 64'(2'b01));
    eng_en = 1'b1;
    qa.push_back(32'd5); qb.push_back(32'd6);
    exp_push.push_back(mk_push(32'd11, 3'd0));
    exp_done.push_back(mk_done(5'd1, 1'b0));
    start_job(1, 5);
    @(negedge clk); chk("t5_error_cleared", 64'(job_error), 64'd0);
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_words = '0; cmd_length = 3'd2;
    @(posedge clk); #1 cmd_start = 1'b0;
    wait_sig(1, 50, "t5_job_done_seen");

    // 6. Reset while waiting on the engine
    qa = '{32'd1, 32'd2}; qb = '{32'd2, 32'd2};
    exp_push.push_back(mk_push(32'd3, 3'd0));
    start_job(3, 7);
    wait_sig(2, 50, "t6_first_push_seen");
    eng_en = 1'b0;
    wait_sig(0, 50, "t6_second_go_seen");
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); chk_zero("t6_after_reset");
    eng_en = 1'b1;
    qa.push_back(32'd7); qb.push_back(32'd1);
    exp_push.push_back(mk_push(32'd8, 3'd0));
    exp_done.push_back(mk_done(5'd1, 1'b0));
    start_job(1, 1);
    wait_sig(1, 50, "t6_job_done_seen");

    repeat (5) @(negedge clk);
    chk("push_queue_drained", 64'(exp_push.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
